calculator: RTL and testbench
=============================

Name: calculator

Overview:
- 4-bit two-operand calculator with a multiplexed 4-digit 7-segment display driver.
- Each cycle it computes one of eight arithmetic/logic operations on A and B and registers the 8-bit result.
- The result is shown in signed decimal: sign, hundreds, tens and ones digits.
- Sits between board switches (A, B, op) and a common-anode 4-digit display.

Parameters:
- REFRESH_CYCLES, default 4: clocks each digit stays enabled before the scan advances. Use about 100000 on hardware.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- A  input  4  first operand, unsigned.
- B  input  4  second operand, unsigned.
- op  input  3  operation select.
- seg  output  7  segment drive, active-low; seg[0]=a … seg[6]=g.
- digit_select  output  4  digit anode enables, active-low; [0]=ones, [1]=tens, [2]=hundreds, [3]=sign.

Behaviour:
- Op encoding and result_bin (8-bit unsigned magnitude):
  - 000 ADD: A+B, range 0..30.
  - 001 SUB: |A-B|; neg=1 when A<B.
  - 010 MUL: A*B, range 0..225.
  - 011 DIV: integer quotient A/B. If B=0: err=1 and result_bin=0.
  - 100 AND, 101 OR, 110 XOR: 4-bit bitwise result, zero-extended.
  - 111 NOT: ~A, 4-bit, zero-extended; B ignored.
- Result register:
  - result_bin, neg and err are registered on every clock.
  - Latency is 1 clock from an A/B/op change to result_bin.
  - Display latency is at most 1 + 4*REFRESH_CYCLES clocks.
- Digit conversion:
  - result_bin (0..255) is converted combinationally to hundreds/tens/ones BCD.
  - Leading zeros are blanked: hundreds blank if 0; tens blank if hundreds and tens are both 0. Ones always shown.
  - Sign digit shows '-' (g only) when neg=1, otherwise blank.
- Error display: when err=1, digits read sign=blank, hundreds='E', tens='r', ones='r'.
- Scan:
  - A refresh counter counts 0..REFRESH_CYCLES-1. On wrap, the 2-bit digit index advances 0→1→2→3→0.
  - digit_select drives low only the bit matching the index.
  - seg is registered together with digit_select, so both change on the same edge.
  - current_digit (internal) holds the 4-bit code for the selected digit: 0–9, or codes for blank, '-', 'E', 'r'.
- Reset (reset=0 at a clock edge):
  - result_bin=0, neg=0, err=0.
  - Refresh counter=0, digit index=0.
  - digit_select=4'b1111 (all off), seg=7'b1111111.
- First cycle after reset release: digit_select=4'b1110 and seg shows the ones digit of the current result_bin.
- Reset mid-scan aborts immediately; the scan restarts at the ones digit.
- Inputs are sampled only at clock edges. Changing A/B/op mid-scan updates the shown digits from the next edge. The scan is not restarted.
- Segment patterns (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111, '-'=0111111, 'E'=0000110, 'r'=0101111.

Decomposition:
- Package calculator_pkg holds:
  - op encodings OP_ADD … OP_NOT;
  - digit codes, including DIG_BLANK, DIG_MINUS, DIG_E, DIG_R;
  - the segment pattern constants.
- One sub-module, seven_seg_decode: pure combinational, 4-bit digit code → 7-bit active-low segments.
- ALU, BCD conversion and scan logic stay in calculator.

Test Plan:
- Reset held low for 2 clocks → result_bin=0, digit_select=1111, seg=1111111. After release → digit_select=1110, seg=1000000 ('0').
- A=1, B=2, op=000 → result_bin=3; ones digit seg=0110000; tens, hundreds and sign blank.
- A=5, B=3, op=001 → result_bin=2, neg=0. Then A=3, B=5 → result_bin=2, neg=1; sign digit seg=0111111.
- A=3, B=3, op=010 → 9. Then A=15, B=15 → 225; hundreds '2', tens '2', ones '5'.
- A=4, B=2, op=011 → 2. Then B=0 → err=1; digits show blank/E/r/r.
- Logic ops:
  - A=1100, B=0011, op=100 → 0.
  - A=1010, B=1100, op=101 → 14.
  - A=1101, B=1011, op=110 → 6.
  - A=1010, op=111 → 5.
  - For each, check the scan cycles 1110→1101→1011→0111 every REFRESH_CYCLES clocks.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared op encodings, digit codes and segment patterns for the calculator.
package calculator_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    // Codes 0-9 are plain decimal digits; the rest are glyphs.
    localparam logic [3:0] DIG_BLANK = 4'd10;
    localparam logic [3:0] DIG_MINUS = 4'd11;
    localparam logic [3:0] DIG_E     = 4'd12;
    localparam logic [3:0] DIG_R     = 4'd13;

    // Active-low, bit order gfedcba.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    typedef struct packed {
        logic [7:0] mag;
        logic       neg;
        logic       err;
    } alu_res_t;

endpackage

// File: rtl/calculator_seven_seg_decode.sv
// Digit code to active-low segment pattern; unknown codes render blank.
module seven_seg_decode
    import calculator_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Pure lookup.
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            4'd8:      seg = SEG_8;
            4'd9:      seg = SEG_9;
            DIG_MINUS: seg = SEG_MINUS;
            DIG_E:     seg = SEG_E;
            DIG_R:     seg = SEG_R;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calculator.sv
// 4-bit calculator: registered ALU result, BCD split, multiplexed 4-digit scan.
module calculator
    import calculator_pkg::*;
#(
    parameter int REFRESH_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [2:0] op,
    output logic [6:0] seg,
    output logic [3:0] digit_select
);

    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    alu_res_t                        alu_nxt;
    logic [7:0]                      result_bin;
    logic                            neg;
    logic                            err;
    logic [3:0]                      hund, tens, ones;
    logic [NUM_DIGITS-1:0][3:0]      dig_code;
    logic [3:0]                      current_digit;
    logic [6:0]                      seg_nxt;
    logic [CNT_W-1:0]                refresh_cnt;
    logic [1:0]                      digit_idx;

    // Next result from the current switch settings.
    always_comb begin
        alu_nxt = '0;
        case (op)
            OP_ADD: alu_nxt.mag = {4'b0, A} + {4'b0, B};
            OP_SUB: begin
                if (A < B) begin
                    alu_nxt.mag = {4'b0, B - A};
                    alu_nxt.neg = 1'b1;
                end else begin
                    alu_nxt.mag = {4'b0, A - B};
                end
            end
            OP_MUL: alu_nxt.mag = {4'b0, A} * {4'b0, B};
            OP_DIV: begin
                if (B == 4'd0) alu_nxt.err = 1'b1;
                else           alu_nxt.mag = {4'b0, A / B};
            end
            OP_AND: alu_nxt.mag = {4'b0, A & B};
            OP_OR:  alu_nxt.mag = {4'b0, A | B};
            OP_XOR: alu_nxt.mag = {4'b0, A ^ B};
            OP_NOT: alu_nxt.mag = {4'b0, ~A};
            default: alu_nxt = '0;
        endcase
    end

    // Result register, refreshed every clock.
    always_ff @(posedge clk) begin
        if (!reset) begin
            result_bin <= '0;
            neg        <= 1'b0;
            err        <= 1'b0;
        end else begin
            result_bin <= alu_nxt.mag;
            neg        <= alu_nxt.neg;
            err        <= alu_nxt.err;
        end
    end

    // Binary to BCD with leading-zero blanking; error overrides everything.
    always_comb begin
        hund = 4'(result_bin / 8'd100);
        tens = 4'((result_bin % 8'd100) / 8'd10);
        ones = 4'(result_bin % 8'd10);
        if (err) begin
            dig_code[3] = DIG_BLANK;
            dig_code[2] = DIG_E;
            dig_code[1] = DIG_R;
            dig_code[0] = DIG_R;
        end else begin
            dig_code[3] = neg ? DIG_MINUS : DIG_BLANK;
            dig_code[2] = (hund == 4'd0) ? DIG_BLANK : hund;
            dig_code[1] = (hund == 4'd0 && tens == 4'd0) ? DIG_BLANK : tens;
            dig_code[0] = ones;
        end
        current_digit = dig_code[digit_idx];
    end

    seven_seg_decode u_dec (
        .code (current_digit),
        .seg  (seg_nxt)
    );

    // Refresh counter and digit index; index steps when the counter wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else if (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= digit_idx + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + CNT_W'(1);
        end
    end

    // Anode enable and segments registered together so they switch on one edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            digit_select <= 4'b1111;
            seg          <= SEG_BLANK;
        end else begin
            digit_select <= ~(4'b0001 << digit_idx);
            seg          <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_calculator.sv
// Self-checking bench for calculator: scoreboard of expected results and displays.
module tb_calculator;

    localparam int R = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic [2:0] op = '0;
    logic [6:0] seg;
    logic [3:0] digit_select;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0]      mag;
        logic            neg;
        logic            err;
        logic [3:0][6:0] s;   // [0]=ones .. [3]=sign
    } exp_t;

    exp_t sb[$];

    calculator #(.REFRESH_CYCLES(R)) dut (
        .clk          (clk),
        .reset        (reset),
        .A            (A),
        .B            (B),
        .op           (op),
        .seg          (seg),
        .digit_select (digit_select)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            11: return 7'b0111111; 12: return 7'b0000110;
            13: return 7'b0101111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic exp_t model(int a, int b, int o);
        exp_t e;
        int m;
        bit ng, er;
        m = 0; ng = 0; er = 0;
        case (o)
            0: m = a + b;
            1: if (a < b) begin m = b - a; ng = 1; end else m = a - b;
            2: m = a * b;
            3: if (b == 0) er = 1; else m = a / b;
            4: m = a & b;
            5: m = a | b;
            6: m = a ^ b;
            default: m = (~a) & 15;
        endcase
        e.mag = 8'(m);
        e.neg = ng;
        e.err = er;
        if (er) begin
            e.s[0] = pat(13); e.s[1] = pat(13); e.s[2] = pat(12); e.s[3] = pat(10);
        end else begin
            e.s[0] = pat(m % 10);
            e.s[1] = (m < 10)  ? pat(10) : pat((m / 10) % 10);
            e.s[2] = (m < 100) ? pat(10) : pat(m / 100);
            e.s[3] = ng ? pat(11) : pat(10);
        end
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (digit_select !== 4'b1111) begin n_fail++; $display("FAIL reset_ds: got %b exp 1111", digit_select); end
            n_checks++;
            if (seg !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg: got %b exp 1111111", seg); end
            n_checks++;
            if (dut.result_bin !== 8'd0 || dut.neg !== 1'b0 || dut.err !== 1'b0) begin
                n_fail++; $display("FAIL reset_result: got %0d/%b/%b exp 0/0/0", dut.result_bin, dut.neg, dut.err);
            end
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (digit_select !== 4'b1110) begin n_fail++; $display("FAIL release_ds: got %b exp 1110", digit_select); end
        n_checks++;
        if (seg !== 7'b1000000) begin n_fail++; $display("FAIL release_seg: got %b exp 1000000", seg); end
    endtask

    task automatic test_arith();
        int ta[9] = '{1, 15, 5, 3, 3, 15, 4, 4, 0};
        int tb[9] = '{2, 15, 3, 5, 3, 15, 2, 0, 0};
        int to[9] = '{0, 0,  1, 1, 2, 2,  3, 3, 1};
        exp_t e;
        int idx;
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            A = 4'(ta[v]); B = 4'(tb[v]); op = 3'(to[v]);
            sb.push_back(model(ta[v], tb[v], to[v]));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (dut.result_bin !== e.mag || dut.neg !== e.neg || dut.err !== e.err) begin
                n_fail++;
                $display("FAIL arith_result[%0d]: got %0d/%b/%b exp %0d/%b/%b", v,
                         dut.result_bin, dut.neg, dut.err, e.mag, e.neg, e.err);
            end
            for (int c = 0; c < 4 * R; c++) begin
                @(posedge clk); #1;
                case (digit_select)
                    4'b1110: idx = 0;
                    4'b1101: idx = 1;
                    4'b1011: idx = 2;
                    4'b0111: idx = 3;
                    default: idx = -1;
                endcase
                n_checks++;
                if (idx < 0) begin
                    n_fail++; $display("FAIL arith_ds[%0d]: got %b exp one-hot-low", v, digit_select);
                end else begin
                    n_checks++;
                    if (seg !== e.s[idx]) begin
                        n_fail++; $display("FAIL arith_seg[%0d] digit %0d: got %b exp %b", v, idx, seg, e.s[idx]);
                    end
                end
            end
        end
    endtask

    task automatic test_logic();
        int ta[5] = '{12, 10, 13, 10, 0};
        int tb[5] = '{3,  12, 11, 0,  9};
        int to[5] = '{4,  5,  6,  7,  7};
        exp_t e;
        int idx, run;
        bit started;
        logic [3:0] prev;
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            A = 4'(ta[v]); B = 4'(tb[v]); op = 3'(to[v]);
            sb.push_back(model(ta[v], tb[v], to[v]));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (dut.result_bin !== e.mag || dut.neg !== e.neg || dut.err !== e.err) begin
                n_fail++;
                $display("FAIL logic_result[%0d]: got %0d/%b/%b exp %0d/%b/%b", v,
                         dut.result_bin, dut.neg, dut.err, e.mag, e.neg, e.err);
            end
            started = 0; run = 0; prev = 4'b0000;
            for (int c = 0; c < 5 * R; c++) begin
                @(posedge clk); #1;
                if (c > 0 && digit_select !== prev) begin
                    n_checks++;
                    if (digit_select !== {prev[2:0], prev[3]}) begin
                        n_fail++; $display("FAIL logic_order[%0d]: got %b after %b", v, digit_select, prev);
                    end
                    if (started) begin
                        n_checks++;
                        if (run !== R) begin n_fail++; $display("FAIL logic_dwell[%0d]: got %0d exp %0d", v, run, R); end
                    end
                    started = 1;
                    run = 0;
                end
                run++;
                prev = digit_select;
                case (digit_select)
                    4'b1110: idx = 0;
                    4'b1101: idx = 1;
                    4'b1011: idx = 2;
                    4'b0111: idx = 3;
                    default: idx = -1;
                endcase
                n_checks++;
                if (idx < 0 || seg !== e.s[(idx < 0) ? 0 : idx]) begin
                    n_fail++; $display("FAIL logic_seg[%0d]: ds %b got %b", v, digit_select, seg);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int a, b, o;
        exp_t e;
        for (int v = 0; v < 24; v++) begin
            @(negedge clk);
            a = int'($urandom_range(15)); b = int'($urandom_range(15)); o = int'($urandom_range(7));
            A = 4'(a); B = 4'(b); op = 3'(o);
            sb.push_back(model(a, b, o));
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (dut.result_bin !== e.mag || dut.neg !== e.neg || dut.err !== e.err) begin
                n_fail++;
                $display("FAIL b2b_result[%0d] a=%0d b=%0d op=%0d: got %0d/%b/%b exp %0d/%b/%b", v, a, b, o,
                         dut.result_bin, dut.neg, dut.err, e.mag, e.neg, e.err);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        exp_t e;
        @(negedge clk);
        A = 4'd15; B = 4'd15; op = 3'd2;
        sb.push_back(model(15, 15, 2));
        repeat (6) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (digit_select !== 4'b1111 || seg !== 7'b1111111 || dut.result_bin !== 8'd0) begin
            n_fail++; $display("FAIL mid_reset: got ds %b seg %b res %0d exp 1111/1111111/0", digit_select, seg, dut.result_bin);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        e = sb.pop_front();
        n_checks++;
        if (digit_select !== 4'b1110 || seg !== 7'b1000000) begin
            n_fail++; $display("FAIL mid_release: got ds %b seg %b exp 1110/1000000", digit_select, seg);
        end
        n_checks++;
        if (dut.result_bin !== e.mag) begin n_fail++; $display("FAIL mid_result: got %0d exp %0d", dut.result_bin, e.mag); end
        for (int c = 0; c < R - 1; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (digit_select !== 4'b1110 || seg !== e.s[0]) begin
                n_fail++; $display("FAIL mid_ones[%0d]: got ds %b seg %b exp 1110/%b", c, digit_select, seg, e.s[0]);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (digit_select !== 4'b1101 || seg !== e.s[1]) begin
            n_fail++; $display("FAIL mid_tens: got ds %b seg %b exp 1101/%b", digit_select, seg, e.s[1]);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_logic();
        test_back_to_back();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
